// File: rtl/time_keeper_set_pkg.sv
// time_keeper_set_pkg: shared clock-domain types and limits for the settable time keeper.
package time_keeper_set_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} mode_t;
    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] HOUR_MAX = 7'd23;
    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
        return (v == max) ? 7'd0 : v + 7'd1;
    endfunction
endpackage

// File: rtl/time_keeper_set_btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer plus previous-value flop giving a one-cycle rise pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic s1, s2, prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= in;
            s2   <= s1;
            prev <= s2;
        end
    end
    assign rise = s2 & ~prev;
endmodule

// File: rtl/time_keeper_set.sv
// time_keeper_set: 24h clock with one-second prescaler and two-button hour/minute setting.
module time_keeper_set
    import time_keeper_set_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [6:0] second,
    output logic [6:0] minute,
    output logic [6:0] hour,
    output logic       sec_tick,
    output logic [1:0] set_mode,
    output logic       blink
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

    logic [CW-1:0] cnt;
    mode_t state, state_nxt;
    logic mode_rise, inc_rise, leave_set;

    btn_sync_edge u_mode (.clk(clk), .rst(rst), .in(btn_mode), .rise(mode_rise));
    btn_sync_edge u_inc  (.clk(clk), .rst(rst), .in(btn_inc),  .rise(inc_rise));

    assign leave_set = (state == SET_MIN) && mode_rise;

    // Leaving the edit restarts the second so the set minute begins cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (sec_tick || leave_set) ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = !mode_rise ? state :
                    (state == RUN) ? SET_HOUR :
                    (state == SET_HOUR) ? SET_MIN : RUN;
    end

    always_comb begin
        set_mode = state;
        sec_tick = (cnt == CNT_LAST);
        blink    = (state != RUN) && (cnt < CNT_HALF);
    end

    // A mode rise in the same cycle swallows any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            second <= '0;
            minute <= '0;
            hour   <= '0;
        end else if (leave_set) begin
            second <= '0;
        end else if (state == RUN && sec_tick) begin
            second <= wrap_inc(second, SEC_MAX);
            if (second == SEC_MAX) begin
                minute <= wrap_inc(minute, MIN_MAX);
                if (minute == MIN_MAX) hour <= wrap_inc(hour, HOUR_MAX);
            end
        end else if (inc_rise && !mode_rise) begin
            if (state == SET_HOUR)     hour   <= wrap_inc(hour, HOUR_MAX);
            else if (state == SET_MIN) minute <= wrap_inc(minute, MIN_MAX);
        end
    end
endmodule

// File: tb/tb_time_keeper_set.sv
// tb_time_keeper_set: directed checks of counting, setting, priority, latency, blink and reset.
module tb_time_keeper_set;
    logic clk = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [6:0] second, minute, hour;
    logic sec_tick, blink;
    logic [1:0] set_mode;
    int total = 0, bad = 0;

    time_keeper_set #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .second(second), .minute(minute), .hour(hour),
        .sec_tick(sec_tick), .set_mode(set_mode), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Two low edges, then high for three edges; returns 1 time unit after the acting edge.
    task automatic press(input logic m, input logic i);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        btn_mode = m;
        btn_inc  = i;
        repeat (3) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    initial begin
        int last, n, found;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // reset mid-edit
        press(1'b1, 1'b0);
        check("pre_set_mode", set_mode, 1);
        press(1'b0, 1'b1);
        check("pre_hour", hour, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_second", second, 0);
        check("rst_minute", minute, 0);
        check("rst_hour", hour, 0);
        check("rst_mode", set_mode, 0);
        check("rst_tick", sec_tick, 0);
        check("rst_blink", blink, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        // counting
        last = -1;
        n = 0;
        for (int i = 1; i <= 240; i++) begin
            @(posedge clk);
            #1;
            if (sec_tick) begin
                if (last >= 0) check("tick_gap", i - last, 4);
                else check("tick_first", i, 3);
                last = i;
                n++;
            end
        end
        check("tick_count", n, 60);
        check("cnt_minute", minute, 1);
        check("cnt_second", second, 0);
        // setting
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        press(1'b1, 1'b0);
        check("set_mode_hour", set_mode, 1);
        repeat (25) press(1'b0, 1'b1);
        check("set_hour_wrap", hour, 1);
        press(1'b1, 1'b0);
        check("set_mode_min", set_mode, 2);
        repeat (61) press(1'b0, 1'b1);
        check("set_min_wrap", minute, 1);
        check("set_min_hour", hour, 1);
        press(1'b1, 1'b0);
        check("set_mode_run", set_mode, 0);
        check("set_sec_clear", second, 0);
        check("set_tick_clear", sec_tick, 0);
        // priority: one tick lands in RUN before the mode rise acts
        press(1'b1, 1'b1);
        check("prio_mode", set_mode, 1);
        check("prio_hour", hour, 1);
        check("prio_second", second, 1);
        // latency of a single inc rise
        repeat (2) @(posedge clk);
        #1 btn_inc = 1'b1;
        @(posedge clk);
        #1 check("lat_e1", hour, 1);
        @(posedge clk);
        #1 check("lat_e2", hour, 1);
        @(posedge clk);
        #1 check("lat_e3", hour, 2);
        btn_inc = 1'b0;
        // blink in SET_HOUR
        found = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (sec_tick) begin
                found = 1;
                break;
            end
        end
        check("blink_sync", found, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 check("blink_set", blink, (i % 4) < 2 ? 1 : 0);
        end
        check("hold_second", second, 1);
        check("hold_minute", minute, 1);
        check("hold_hour", hour, 2);
        // rollover
        repeat (21) press(1'b0, 1'b1);
        check("roll_hour_set", hour, 23);
        press(1'b1, 1'b0);
        repeat (58) press(1'b0, 1'b1);
        check("roll_min_set", minute, 59);
        press(1'b1, 1'b0);
        check("roll_run", set_mode, 0);
        repeat (236) @(posedge clk);
        #1;
        check("roll_pre_s", second, 59);
        check("roll_pre_m", minute, 59);
        check("roll_pre_h", hour, 23);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("blink_run", blink, 0);
        end
        check("roll_s", second, 0);
        check("roll_m", minute, 0);
        check("roll_h", hour, 0);
        // inc ignored in RUN
        press(1'b0, 1'b1);
        check("run_inc_h", hour, 0);
        check("run_inc_m", minute, 0);
        check("run_inc_mode", set_mode, 0);
        // button held through reset release
        rst = 1'b1;
        btn_mode = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check("held_e1", set_mode, 0);
        @(posedge clk);
        #1 check("held_e2", set_mode, 0);
        @(posedge clk);
        #1 check("held_e3", set_mode, 1);
        btn_mode = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
